alu_arbiter: RTL
================

# alu_arbiter

Shares a single `alu` instance between two requesters, port 0 and port 1, using round-robin arbitration. The arbiter latches the granted requester's opcode and operands and drives them to the ALU. It then captures `ALUout`, `Overflow` and `Zero` into a per-port result register and pulses that port's done signal. The block sits between the datapath clients and the ALU, and it is the only driver of the ALU's inputs.

## Interface
- `W`, 64, datapath width. It must match the `alu` instance.

- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous reset, active-high.
- `req0` / `req1` input 1: request from port 0 / port 1.
- `ctl0` / `ctl1` input 4: ALU opcode: AND=0000, OR=0001, ADD=0010, SUB=0110, LESSTHAN=0111, NOR=1100.
- `a0`, `b0` / `a1`, `b1` input W: operands.
- `gnt0` / `gnt1` output 1: one-cycle pulse meaning the request was accepted and its operands are latched.
- `done0` / `done1` output 1: one-cycle pulse meaning the result registers of that port are updated.
- `res0` / `res1` output W: last result for that port.
- `ovf0` / `ovf1`, `zero0` / `zero1` output 1: last Overflow and Zero for that port.
- `busy` output 1: high whenever the state is not IDLE.
- `alu_ctl` output 4, `alu_a`, `alu_b` output W: drive the ALU inputs.
- `alu_out` input W, `alu_ovf` input 1, `alu_zero` input 1: from the ALU outputs.

## Operation
- FSM states: IDLE, EXEC, DONE.
  - IDLE to EXEC when `req0 | req1` is high at the clock edge.
  - EXEC to DONE unconditionally.
  - DONE to IDLE unconditionally.
- Requests are sampled only in IDLE. A `req` that is high in EXEC or DONE is ignored until the FSM returns to IDLE.
- Arbitration:
  - The `last` register holds the index of the most recently granted port. Reset value is 1, so port 0 wins first.
  - If only one port requests, that port is granted.
  - If both request, the port `!last` is granted.
  - `last` updates on every grant.
- On the IDLE to EXEC edge:
  - `op_ctl`, `op_a`, `op_b` load from the granted port.
  - `sel` records which port was granted.
  - `gnt[sel]` is set to 1. It is registered and high for exactly the EXEC cycle.
- The operand registers drive `alu_ctl`, `alu_a`, `alu_b` directly. They hold their value through DONE and IDLE until the next grant.
- On the EXEC to DONE edge:
  - `res[sel]`, `ovf[sel]`, `zero[sel]` load `alu_out`, `alu_ovf`, `alu_zero`.
  - `done[sel]` is set to 1. It is registered and high for exactly the DONE cycle.
  - The other port's result registers are unchanged.
- A requester may drop `req` or change its operands from the cycle after `gnt` onward. If it keeps `req` high, that is a new request, re-sampled in the next IDLE.
- Opcodes are passed through unchecked. Undefined codes produce whatever the ALU outputs.
- The arbiter performs no arithmetic of its own. All width, overflow and zero semantics are those of the ALU.

## Timing
- Reset, applied asynchronously at any time:
  - state becomes IDLE and `last` becomes 1.
  - `gnt*`, `done*`, `busy` become 0.
  - `res*`, `ovf*`, `zero*` become 0.
  - `alu_ctl` becomes 0000; `alu_a`, `alu_b` become 0.
  - An operation in progress is discarded and no `done` is issued.
- Latency, with `req` high in IDLE at edge t:
  - `gnt` is high in cycle t+1 (EXEC).
  - `done` is high in cycle t+2 (DONE), and `res` is valid from t+2.
- Throughput is at most one operation per 3 cycles. With both ports requesting continuously, the grant order is 0, 1, 0, 1, …
- Simultaneous `req0` and `req1` in IDLE: only one `gnt` is issued. `gnt0` and `gnt1` are never high together, and neither are `done0` and `done1`.
- `busy` is a registered decode of the state: high in EXEC and DONE.
- The ALU path is combinational. `alu_out` must settle within the EXEC cycle.

## Test plan
- SUB overflow case: reset, then `req0` with `ctl0`=0110, `a0`=0x8000000000000000, `b0`=1 for one cycle.
  - `gnt0` pulses 1 cycle later and `done0` 2 cycles later.
  - `res0`=0x7FFFFFFFFFFFFFFF, `ovf0`=1, `zero0`=0.
  - Port 1 outputs stay 0.
- Zero flag: `req1` with ADD, `a1`=5, `b1`=0xFFFFFFFFFFFFFFFB.
  - `done1` pulses, `res1`=0, `zero1`=1, `ovf1`=0.
  - `res0` is unchanged.
- Simultaneous requests after reset: `req0` with OR 0xF0 and 0x0F, `req1` with NOR 0 and 0.
  - Port 0 is served first: `res0`=0xFF.
  - 3 cycles later port 1 is served: `res1`=0xFFFFFFFFFFFFFFFF.
- Continuous contention: both `req` held high for 12 cycles.
  - Exactly 4 grants, in order 0, 1, 0, 1.
  - `gnt0` and `gnt1` are never both high.
  - `busy` is low only in the IDLE cycles.
- LESSTHAN: `req0` with `a0`=3, `b0`=7 gives `res0`=1. A second request with `a0`=7, `b0`=3 gives `res0`=0.
- Reset mid-operation: assert `rst` during EXEC.
  - No `done` is issued.
  - All outputs return to their reset values immediately, without waiting for a clock edge.
  - After reset is released, a pending `req1` alone is granted normally.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// A grant latches the winner's opcode and operands; the ALU result is captured one cycle later.
module alu_arbiter #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic         req1,
   input  logic [3:0]   ctl0,
   input  logic [3:0]   ctl1,
   input  logic [W-1:0] a0,
   input  logic [W-1:0] b0,
   input  logic [W-1:0] a1,
   input  logic [W-1:0] b1,
   output logic         gnt0,
   output logic         gnt1,
   output logic         done0,
   output logic         done1,
   output logic [W-1:0] res0,
   output logic [W-1:0] res1,
   output logic         ovf0,
   output logic         ovf1,
   output logic         zero0,
   output logic         zero1,
   output logic         busy,
   output logic [3:0]   alu_ctl,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   input  logic [W-1:0] alu_out,
   input  logic         alu_ovf,
   input  logic         alu_zero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              last_q, last_d;
   logic              sel_q, sel_d;
   logic              grant;
   logic [1:0]        gnt_q, gnt_d;
   logic [1:0]        done_q, done_d;
   logic              busy_q, busy_d;
   logic [3:0]        op_ctl_q, op_ctl_d;
   logic [W-1:0]      op_a_q, op_a_d;
   logic [W-1:0]      op_b_q, op_b_d;
   logic [1:0][W-1:0] res_q, res_d;
   logic [1:0]        ovf_q, ovf_d;
   logic [1:0]        zero_q, zero_d;

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      sel_d    = sel_q;
      grant    = 1'b0;
      gnt_d    = 2'b00;
      done_d   = 2'b00;
      op_ctl_d = op_ctl_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      res_d    = res_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;

      case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               // On contention the port that did not win last time goes first.
               grant        = (req0 & req1) ? ~last_q : req1;
               last_d       = grant;
               sel_d        = grant;
               gnt_d[grant] = 1'b1;
               op_ctl_d     = grant ? ctl1 : ctl0;
               op_a_d       = grant ? a1 : a0;
               op_b_d       = grant ? b1 : b0;
               state_d      = EXEC;
            end
         end
         EXEC: begin
            res_d[sel_q]  = alu_out;
            ovf_d[sel_q]  = alu_ovf;
            zero_d[sel_q] = alu_zero;
            done_d[sel_q] = 1'b1;
            state_d       = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;
         sel_q    <= 1'b0;
         gnt_q    <= 2'b00;
         done_q   <= 2'b00;
         busy_q   <= 1'b0;
         op_ctl_q <= 4'b0000;
         op_a_q   <= '0;
         op_b_q   <= '0;
         res_q    <= '0;
         ovf_q    <= 2'b00;
         zero_q   <= 2'b00;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         sel_q    <= sel_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         op_ctl_q <= op_ctl_d;
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
         res_q    <= res_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
      end
   end

   assign gnt0    = gnt_q[0];
   assign gnt1    = gnt_q[1];
   assign done0   = done_q[0];
   assign done1   = done_q[1];
   assign busy    = busy_q;
   assign res0    = res_q[0];
   assign res1    = res_q[1];
   assign ovf0    = ovf_q[0];
   assign ovf1    = ovf_q[1];
   assign zero0   = zero_q[0];
   assign zero1   = zero_q[1];
   assign alu_ctl = op_ctl_q;
   assign alu_a   = op_a_q;
   assign alu_b   = op_b_q;

endmodule
